instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issues sequential imem requests, tracks stale in-flight
// responses across redirects and buffers {pc, data} for decode.
module instruction_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     DEPTH    = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [XLEN-1:0] STEP    = XLEN'(4);
   localparam logic [PW-1:0]   ONE_P   = PW'(1);
   localparam logic [CW-1:0]   ONE_C   = CW'(1);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_count;
   logic [CW-1:0]   fifo_count;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;

   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [XLEN-1:0] data_mem [DEPTH];

   logic [CW-1:0]   live;
   logic [CW:0]     occupancy;
   logic            req_fire;
   logic            push;
   logic            pop;
   logic            drop;
   logic [XLEN-1:0] target_aligned;

   always_comb begin
      live      = outstanding - drop_count;
      occupancy = {1'b0, fifo_count} + {1'b0, live};
      // buffer space is reserved for every live request before it is issued
      imem_req_valid = !reset && !redirect_valid
                       && (occupancy < {1'b0, DEPTH_C})
                       && (outstanding < DEPTH_C);
      imem_req_addr  = fetch_pc;
      req_fire       = imem_req_valid && imem_req_ready;
      inst_valid     = (fifo_count != '0);
      inst_data      = data_mem[head];
      inst_pc        = pc_mem[head];
      push           = imem_resp_valid && !redirect_valid
                       && (drop_count == '0);
      drop           = imem_resp_valid && !redirect_valid
                       && (drop_count != '0);
      pop            = inst_valid && inst_ready && !redirect_valid;
      target_aligned = {redirect_target[XLEN-1:2], 2'b00};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_count  <= '0;
         fifo_count  <= '0;
         head        <= '0;
         tail        <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= target_aligned;
         resp_pc     <= target_aligned;
         head        <= '0;
         tail        <= '0;
         fifo_count  <= '0;
         // every request still in flight after this cycle is stale
         outstanding <= outstanding - CW'(imem_resp_valid);
         drop_count  <= outstanding - CW'(imem_resp_valid);
      end else begin
         if (req_fire)
            fetch_pc <= fetch_pc + STEP;
         if (push) begin
            tail    <= tail + ONE_P;
            resp_pc <= resp_pc + STEP;
         end
         if (pop)
            head <= head + ONE_P;
         if (drop)
            drop_count <= drop_count - ONE_C;
         case ({req_fire, imem_resp_valid})
            2'b10:   outstanding <= outstanding + ONE_C;
            2'b01:   outstanding <= outstanding - ONE_C;
            default: outstanding <= outstanding;
         endcase
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + ONE_C;
            2'b01:   fifo_count <= fifo_count - ONE_C;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         pc_mem[tail]   <= resp_pc;
         data_mem[tail] <= imem_resp_data;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order memory model with configurable
// latency and a scoreboard of expected instruction addresses.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   int errors = 0;
   int checks = 0;
   int lat = 1;
   int edge_n = 0;

   logic [31:0] exp_q[$];
   logic [31:0] req_log[$];

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        pend[$];
   req_t        mem_r;
   logic        fire_s = 1'b0;
   logic        rsp_s = 1'b0;
   logic [31:0] addr_s = '0;

   instruction_fetch_unit #(
      .XLEN(32),
      .RESET_PC(RESET_PC),
      .DEPTH(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .redirect_valid(redirect_valid),
      .redirect_target(redirect_target),
      .imem_req_valid(imem_req_valid),
      .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .inst_data(inst_data),
      .inst_pc(inst_pc)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // memory model: sample handshakes at negedge, update just after posedge
   always @(negedge clock) begin
      fire_s = !reset && imem_req_valid && imem_req_ready;
      addr_s = imem_req_addr;
      rsp_s  = imem_resp_valid;
      if (fire_s)
         req_log.push_back(imem_req_addr);
   end

   always @(posedge clock) begin
      edge_n++;
      #1;
      if (reset) begin
         pend.delete();
      end else begin
         if (rsp_s && pend.size() > 0)
            pend.delete(0);
         if (fire_s) begin
            mem_r.addr = addr_s;
            mem_r.due  = edge_n + lat - 1;
            pend.push_back(mem_r);
         end
      end
      if (!reset && pend.size() > 0 && pend[0].due <= edge_n) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(pend[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
   end

   // scoreboard: every head word must match memory; pops follow exp_q
   always @(negedge clock) begin
      if (!reset && inst_valid) begin
         checks++;
         if (inst_data !== mem_word(inst_pc)) begin
            errors++;
            $display("FAIL inst_data@%h: got %h want %h",
                     inst_pc, inst_data, mem_word(inst_pc));
         end
         if (inst_ready && !redirect_valid && exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (inst_pc !== e) begin
               errors++;
               $display("FAIL pop_order: got pc %h want %h", inst_pc, e);
            end
         end
      end
   end

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      req_log.delete();
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d left want 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
      end
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
      end
      checks++;
      if (imem_req_addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_addr: got %h want %h", imem_req_addr, RESET_PC);
      end
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         errors++;
         $display("FAIL first_req: got %b/%h want 1/%h",
                  imem_req_valid, imem_req_addr, RESET_PC);
      end
   endtask

   task automatic test_streaming();
      int n;
      lat = 1;
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++)
         exp_q.push_back(32'(i * 4));
      n = 0;
      @(negedge clock);
      while (!inst_valid && n < 10) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL stream_latency: got %0d want 2", n);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_gap: cycle %0d got %b want 1", i, inst_valid);
         end
         @(negedge clock);
      end
      drain("stream", 10);
   endtask

   task automatic test_backpressure();
      int n;
      lat = 1;
      imem_req_ready = 1'b1;
      inst_ready = 1'b0;
      do_reset();
      repeat (12) @(negedge clock);
      checks++;
      if (req_log.size() !== 4) begin
         errors++;
         $display("FAIL bp_req_count: got %0d want 4", req_log.size());
      end
      for (int i = 0; i < 4 && i < req_log.size(); i++) begin
         checks++;
         if (req_log[i] !== 32'(i * 4)) begin
            errors++;
            $display("FAIL bp_req_addr: got %h want %h", req_log[i], i * 4);
         end
      end
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_stall: got %b want 0", imem_req_valid);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_hold: got %b/%h want 1/0", inst_valid, inst_pc);
         end
         @(negedge clock);
      end
      for (int i = 0; i < 6; i++)
         exp_q.push_back(32'(i * 4));
      @(posedge clock);
      #1;
      inst_ready = 1'b1;
      n = 0;
      while (req_log.size() < 5 && n < 6) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (req_log.size() < 5) begin
         errors++;
         $display("FAIL bp_resume: got %0d reqs want 5", req_log.size());
      end else if (req_log[4] !== 32'h10) begin
         errors++;
         $display("FAIL bp_resume: got %h want 00000010", req_log[4]);
      end
      drain("bp", 20);
   endtask

   task automatic test_redirect_inflight();
      int n;
      int fires;
      lat = 3;
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      do_reset();
      n = 0;
      fires = 0;
      while (fires < 3 && n < 10) begin
         @(negedge clock);
         if (imem_req_valid && imem_req_ready)
            fires++;
         n++;
      end
      checks++;
      if (fires !== 3 || imem_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_setup: got %0d fired resp %b want 3 resp 0",
                  fires, imem_resp_valid);
      end
      @(posedge clock);
      #1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h103;
      exp_q.delete();
      for (int i = 0; i < 4; i++)
         exp_q.push_back(32'h100 + 32'(i * 4));
      @(negedge clock);
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_block: got %b want 0", imem_req_valid);
      end
      @(posedge clock);
      #1;
      redirect_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
         errors++;
         $display("FAIL rd_target: got %b/%h want 1/00000100",
                  imem_req_valid, imem_req_addr);
      end
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_flush: got %b want 0", inst_valid);
      end
      drain("rd", 40);
   endtask

   task automatic test_redirect_coincident();
      int n;
      lat = 2;
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++)
         exp_q.push_back(32'(i * 4));
      n = 0;
      @(negedge clock);
      while (!(inst_valid && imem_resp_valid) && n < 10) begin
         @(negedge clock);
         n++;
      end
      @(posedge clock);
      #1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h200;
      exp_q.delete();
      for (int i = 0; i < 3; i++)
         exp_q.push_back(32'h200 + 32'(i * 4));
      @(negedge clock);
      checks++;
      if (imem_resp_valid !== 1'b1 || inst_valid !== 1'b1) begin
         errors++;
         $display("FAIL rc_setup: got resp %b inst %b want 1 1",
                  imem_resp_valid, inst_valid);
      end
      @(posedge clock);
      #1;
      redirect_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL rc_flush: got %b want 0", inst_valid);
      end
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
         errors++;
         $display("FAIL rc_target: got %b/%h want 1/00000200",
                  imem_req_valid, imem_req_addr);
      end
      drain("rc", 30);
   endtask

   task automatic test_wrap();
      lat = 1;
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      do_reset();
      @(posedge clock);
      #1;
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      exp_q.delete();
      req_log.delete();
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      @(posedge clock);
      #1;
      redirect_valid = 1'b0;
      drain("wrap", 20);
      checks++;
      if (req_log.size() < 2) begin
         errors++;
         $display("FAIL wrap_req: got %0d reqs want 2+", req_log.size());
      end else if (req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
         errors++;
         $display("FAIL wrap_req: got %h,%h want fffffffc,00000000",
                  req_log[0], req_log[1]);
      end
   endtask

   task automatic test_async_reset();
      lat = 1;
      imem_req_ready = 1'b1;
      inst_ready = 1'b0;
      do_reset();
      @(posedge clock);
      #1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h400;
      @(posedge clock);
      #1;
      redirect_valid = 1'b0;
      repeat (10) @(negedge clock);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h400 || imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL ar_full: got %b/%h/%b want 1/00000400/0",
                  inst_valid, inst_pc, imem_req_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL ar_immediate: got %b/%b want 0/0",
                  inst_valid, imem_req_valid);
      end
      exp_q.delete();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      inst_ready = 1'b1;
      @(negedge clock);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         errors++;
         $display("FAIL ar_first_req: got %b/%h want 1/%h",
                  imem_req_valid, imem_req_addr, RESET_PC);
      end
      drain("ar", 20);
   endtask

   task automatic test_random_handshake();
      int n;
      lat = 2;
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 40; i++)
         exp_q.push_back(32'(i * 4));
      n = 0;
      while (exp_q.size() != 0 && n < 800) begin
         @(posedge clock);
         #1;
         imem_req_ready = ($urandom_range(0, 3) != 0);
         inst_ready     = ($urandom_range(0, 2) != 0);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rand_drain: got %0d left want 0", exp_q.size());
      end
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_coincident();
      test_wrap();
      test_async_reset();
      test_random_handshake();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
